// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  localparam int WORD_W = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and load/store (option FETCH_STARVE_GUARD_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
`ifdef FETCH_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [WORD_W-1:0] ls_addr,
  input  logic [WORD_W-1:0] ls_wdata,
  output logic [WORD_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              stall_if,
  output logic              stall_ls,
  output logic              m_en,
  output logic              m_we,
  output logic [WORD_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
);
  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic             grant_ls, grant_if;
`ifdef FETCH_STARVE_GUARD_EN
  logic [7:0]       starve;
  assign grant_ls = ls_req && !(if_req && starve == 8'(STARVE_MAX));
`else
  assign grant_ls = ls_req;
`endif
  assign grant_if = if_req && !grant_ls;
  assign stall_if = if_req & ~if_valid;
  assign stall_ls = ls_req & ~ls_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      cnt      <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
`ifdef FETCH_STARVE_GUARD_EN
      starve   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (grant_ls || grant_if) begin
          owner   <= grant_ls ? OWN_LS : OWN_IF;
          m_addr  <= grant_ls ? ls_addr : if_addr;
          m_wdata <= ls_wdata;
          m_we    <= grant_ls & ls_we;
          m_en    <= 1'b1;
          state   <= ISSUE;
`ifdef FETCH_STARVE_GUARD_EN
          starve  <= (grant_ls && if_req) ? starve + 8'd1 : '0;
`endif
        end
        ISSUE: begin
          m_en  <= 1'b0;
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          // stores leave both read registers untouched
          if (!m_we && owner == OWN_LS) ls_rdata <= m_rdata;
          if (!m_we && owner == OWN_IF) if_rdata <= m_rdata;
          ls_valid <= owner == OWN_LS;
          if_valid <= owner == OWN_IF;
          state    <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          if_valid <= 1'b0;
          ls_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_arbiter;
  typedef struct {
    logic        ls;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          cyc;
  } acc_t;

  logic clk = 0;
  logic rst = 1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [15:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic [15:0] if_rdata, ls_rdata, m_addr, m_wdata, m_rdata;
  logic        if_valid, ls_valid, stall_if, stall_ls, m_en, m_we;

  logic        b_ls_req = 0, b_ls_we = 0;
  logic [15:0] b_ls_addr = 0, b_ls_wdata = 0;
  logic [15:0] b_if_rdata, b_ls_rdata, b_m_addr, b_m_wdata, b_m_rdata;
  logic        b_if_valid, b_ls_valid, b_stall_if, b_stall_ls, b_m_en, b_m_we;

  mem_port_arbiter #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .stall_if(stall_if),
    .stall_ls(stall_ls), .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(1'b0), .if_addr(16'h0000), .if_rdata(b_if_rdata),
    .if_valid(b_if_valid), .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr),
    .ls_wdata(b_ls_wdata), .ls_rdata(b_ls_rdata), .ls_valid(b_ls_valid), .stall_if(b_stall_if),
    .stall_ls(b_stall_ls), .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_rdata(b_m_rdata)
  );

  // memory content: one fixed word, everything else is addr ^ 5A5A; DEAD marks a wrong-cycle read
  function automatic logic [15:0] word(input logic [15:0] a);
    return a == 16'h0010 ? 16'hBEEF : a ^ 16'h5A5A;
  endfunction

  logic [15:0] p1 = 16'hDEAD;
  logic [15:0] p3 [3] = '{16'hDEAD, 16'hDEAD, 16'hDEAD};
  always @(posedge clk) begin
    p1 <= m_en ? word(m_addr) : 16'hDEAD;
    p3[0] <= b_m_en ? word(b_m_addr) : 16'hDEAD;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign m_rdata = p1;
  assign b_m_rdata = p3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  acc_t acc1[$], fly1[$], acc3[$], fly3[$];

  task automatic push1(input logic ls, input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] r, input int c);
    acc1.push_back('{ls, we, a, d, r, c});
  endtask

  task automatic push3(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] r, input int c);
    acc3.push_back('{1'b1, we, a, d, r, c});
  endtask

  always @(negedge clk) begin : mon1
    acc_t a;
    if (!rst && m_en) begin
      chk("m_en_expected", 32'(acc1.size() != 0), 1);
      if (acc1.size() != 0) begin
        a = acc1.pop_front();
        chk("m_we", 32'(m_we), 32'(a.we));
        chk("m_addr", 32'(m_addr), 32'(a.addr));
        if (a.we) chk("m_wdata", 32'(m_wdata), 32'(a.wdata));
        if (a.cyc >= 0) chk("m_en_cycle", cyc, a.cyc);
        a.cyc = cyc;
        fly1.push_back(a);
      end
    end
    if (!rst && (if_valid || ls_valid)) begin
      chk("valid_expected", 32'(fly1.size() != 0), 1);
      if (fly1.size() != 0) begin
        a = fly1.pop_front();
        chk("valid_owner", 32'({if_valid, ls_valid}), 32'(a.ls ? 2'b01 : 2'b10));
        chk("valid_cycle", cyc, a.cyc + 2);
        if (!a.we) chk("rdata", 32'(a.ls ? ls_rdata : if_rdata), 32'(a.rdata));
      end
    end
  end

  always @(negedge clk) begin : mon3
    acc_t a;
    if (!rst && b_m_en) begin
      chk("b_m_en_expected", 32'(acc3.size() != 0), 1);
      if (acc3.size() != 0) begin
        a = acc3.pop_front();
        chk("b_m_we", 32'(b_m_we), 32'(a.we));
        chk("b_m_addr", 32'(b_m_addr), 32'(a.addr));
        if (a.we) chk("b_m_wdata", 32'(b_m_wdata), 32'(a.wdata));
        chk("b_m_en_cycle", cyc, a.cyc);
        a.cyc = cyc;
        fly3.push_back(a);
      end
    end
    if (!rst && (b_if_valid || b_ls_valid)) begin
      chk("b_valid_expected", 32'(fly3.size() != 0), 1);
      if (fly3.size() != 0) begin
        a = fly3.pop_front();
        chk("b_valid_owner", 32'({b_if_valid, b_ls_valid}), 32'(2'b01));
        chk("b_valid_cycle", cyc, a.cyc + 4);
        if (!a.we) chk("b_rdata", 32'(b_ls_rdata), 32'(a.rdata));
      end
    end
  end

  // checks the stall line every cycle until the completion pulse
  task automatic wait_valid(input bit ls);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ls ? ls_valid : if_valid;
      chk(ls ? "stall_ls" : "stall_if", 32'(ls ? stall_ls : stall_if), 32'(!ok));
    end
    chk("valid_in_time", 32'(ok), 1);
  endtask

  task automatic do_if(input logic [15:0] a);
    if_req = 1;
    if_addr = a;
    wait_valid(0);
    @(posedge clk); #1;
    if_req = 0;
  endtask

  task automatic do_ls(input logic we, input logic [15:0] a, input logic [15:0] d);
    ls_req = 1;
    ls_we = we;
    ls_addr = a;
    ls_wdata = d;
    wait_valid(1);
    @(posedge clk); #1;
    ls_req = 0;
  endtask

  task automatic do_b(input logic we, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] r);
    int  r0;
    bit  ok;
    r0 = cyc;
    ok = 0;
    push3(we, a, d, r, r0 + 1);
    b_ls_req = 1;
    b_ls_we = we;
    b_ls_addr = a;
    b_ls_wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = b_ls_valid;
    end
    chk("b_valid_in_time", 32'(ok), 1);
    chk("b_valid_after_grant", cyc, r0 + 5);
    @(posedge clk); #1;
    b_ls_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_en", 32'(m_en), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_wdata", 32'(m_wdata), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_ls_valid", 32'(ls_valid), 0);
    chk("rst_if_rdata", 32'(if_rdata), 0);
    chk("rst_ls_rdata", 32'(ls_rdata), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // single fetch
    push1(0, 0, 16'h0010, 0, 16'hBEEF, cyc + 1);
    do_if(16'h0010);

    // simultaneous: LS first, IF at the next IDLE
    r = cyc;
    push1(1, 0, 16'h0200, 0, 16'h585A, r + 1);
    push1(0, 0, 16'h0300, 0, 16'h595A, r + 5);
    fork
      do_ls(0, 16'h0200, 16'h0000);
      do_if(16'h0300);
    join

    // back-to-back loads with ls_req held
    r = cyc;
    push1(1, 0, 16'h0020, 0, 16'h5A7A, r + 1);
    push1(1, 0, 16'h0022, 0, 16'h5A78, r + 5);
    push1(1, 0, 16'h0024, 0, 16'h5A7E, r + 9);
    ls_we = 0;
    ls_addr = 16'h0020;
    ls_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(1);
      @(posedge clk); #1;
      if (k < 2) ls_addr = ls_addr + 16'h0002;
      else ls_req = 0;
    end

    // reset during WAIT abandons the fetch
    r = cyc;
    push1(0, 0, 16'h0050, 0, 16'h0000, r + 1);
    if_addr = 16'h0050;
    if_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = m_en;
    end
    chk("t5_m_en_seen", 32'(seen), 1);
    @(posedge clk); #1;
    rst = 1;
    if_req = 0;
    fly1.delete();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("t5_m_en", 32'(m_en), 0);
    chk("t5_if_valid", 32'(if_valid), 0);
    chk("t5_ls_valid", 32'(ls_valid), 0);
    chk("t5_if_rdata", 32'(if_rdata), 0);
    chk("t5_ls_rdata", 32'(ls_rdata), 0);
    repeat (5) begin
      @(negedge clk);
      chk("t5_no_valid", 32'(if_valid | ls_valid), 0);
    end
    @(posedge clk); #1;

    // both requests held: grant order depends on the starve guard
    r = cyc;
    for (int i = 0; i < 6; i++) begin
`ifdef FETCH_STARVE_GUARD_EN
      if (i == 4) push1(0, 0, 16'h0300, 0, 16'h595A, r + 1 + 4 * i);
      else
`endif
      push1(1, 0, 16'h0100, 0, 16'h5B5A, r + 1 + 4 * i);
    end
    ls_we = 0;
    ls_addr = 16'h0100;
    if_addr = 16'h0300;
    ls_req = 1;
    if_req = 1;
    repeat (24) @(posedge clk);
    #1;
    ls_req = 0;
    if_req = 0;
    repeat (6) @(posedge clk);
    #1;

    // MEM_LAT=3 store, then a load
    do_b(1, 16'h0040, 16'h1234, 16'h0000);
    do_b(0, 16'h0044, 16'h0000, 16'h5A1E);

    repeat (6) @(negedge clk);
    chk("acc1_drained", acc1.size(), 0);
    chk("fly1_drained", fly1.size(), 0);
    chk("acc3_drained", acc3.size(), 0);
    chk("fly3_drained", fly3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
